// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM.
// q changes only after DEBOUNCE_CYCLES consecutive synchronized samples at the new level.
module sync_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d,
   output logic       q,
   output logic       rise,
   output logic       fall,
   output logic       busy,
   output logic [1:0] state_dbg
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Pending states share bit 0, so busy is a single flop bit and cannot glitch.
   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      PEND_HI   = 2'b01,
      STABLE_HI = 2'b10,
      PEND_LO   = 2'b11
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          s1;
   logic          s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= STABLE_LO;
         cnt   <= '0;
         q     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (s2) begin
                  state <= PEND_HI;
                  cnt   <= CW'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            PEND_HI: begin
               if (!s2) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
                  q     <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt   <= cnt + CW'(1);
               end
            end
            STABLE_HI: begin
               if (!s2) begin
                  state <= PEND_LO;
                  cnt   <= CW'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            PEND_LO: begin
               if (s2) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
                  q     <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt   <= cnt + CW'(1);
               end
            end
            default: begin
               state <= STABLE_LO;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign busy      = state[0];
   assign state_dbg = state;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed and randomized checks of sync_debounce against a run-length reference model.
module tb_sync_debounce;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       d   = 1'b0;
   logic       q, rise, fall, busy;
   logic [1:0] state_dbg;

   int errors = 0;
   int checks = 0;

   // Reference: level seen by the control logic lags d by two edges; q flips
   // after DC consecutive samples that differ from it.
   logic m_s1, m_s2, m_q, m_rise, m_fall;
   int   m_run;
   logic [3:0] exp_q[$];

   sync_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .d(d), .q(q), .rise(rise), .fall(fall),
      .busy(busy), .state_dbg(state_dbg)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_q = 0; m_rise = 0; m_fall = 0; m_run = 0;
      exp_q.delete();
   endtask

   // Called at a falling edge: drive d, advance one rising edge, compare at the next falling edge.
   task automatic tick(input logic dv);
      logic [3:0] e;
      d = dv;
      @(posedge clk);
      m_rise = 0;
      m_fall = 0;
      if (m_s2 != m_q) begin
         m_run++;
         if (m_run == DC) begin
            m_q    = m_s2;
            m_rise = m_q;
            m_fall = !m_q;
            m_run  = 0;
         end
      end else begin
         m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = dv;
      exp_q.push_back({m_q, m_rise, m_fall, (m_run != 0)});
      @(negedge clk);
      e = exp_q.pop_front();
      check("model_q_rise_fall_busy", {q, rise, fall, busy}, e);
   endtask

   // Assert reset between edges, confirm outputs clear without an edge, release at a falling edge.
   task automatic do_reset();
      #5;
      rst = 1'b0;
      #1;
      check("async_reset_outputs", {q, rise, fall, busy}, 4'b0000);
      check("async_reset_state", {2'b00, state_dbg}, 4'b0000);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int rises, falls, len;
      logic busy_seen, q0, dv;

      model_reset();
      #5;
      check("reset_initial", {q, rise, fall, busy}, 4'b0000);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b0);

      // Clean rise
      for (int k = 1; k <= 7; k++) begin
         tick(1'b1);
         if (k >= 3 && k <= 5) check("rise_busy", {3'b0, busy}, 4'b0001);
         if (k == 6) check("rise_edge6_q_rise", {2'b0, q, rise}, 4'b0011);
         if (k == 7) check("rise_edge7_rise_low", {3'b0, rise}, 4'b0000);
      end
      for (int i = 0; i < 2; i++) tick(1'b1);

      // Clean fall
      for (int k = 1; k <= 7; k++) begin
         tick(1'b0);
         if (k >= 3 && k <= 5) check("fall_busy", {3'b0, busy}, 4'b0001);
         if (k == 6) check("fall_edge6_q_fall", {2'b0, q, fall}, 4'b0001);
         if (k == 7) check("fall_edge7_fall_low", {3'b0, fall}, 4'b0000);
      end
      for (int i = 0; i < 2; i++) tick(1'b0);

      // Glitch: two cycles high then back low
      busy_seen = 0;
      rises = 0;
      for (int k = 0; k < 8; k++) begin
         tick(k < 2);
         busy_seen |= busy;
         rises += int'(rise);
      end
      check("glitch_busy_pulsed", {3'b0, busy_seen}, 4'b0001);
      check("glitch_no_rise", rises[3:0], 4'b0000);
      check("glitch_q_low", {3'b0, q}, 4'b0000);
      check("glitch_state_stable_lo", {2'b00, state_dbg}, 4'b0000);

      // Reset while pending high, release with d low
      for (int k = 0; k < 4; k++) tick(1'b1);
      check("midpend_busy_before", {3'b0, busy}, 4'b0001);
      do_reset();
      rises = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1'b0);
         rises += int'(rise);
      end
      check("midpend_no_rise", rises[3:0], 4'b0000);
      check("midpend_q_busy", {2'b0, q, busy}, 4'b0000);

      // Async reset from q=1 with d high, then d high at release qualifies normally
      for (int k = 0; k < 8; k++) tick(1'b1);
      check("pre_async_q_high", {3'b0, q}, 4'b0001);
      do_reset();
      rises = 0;
      for (int k = 1; k <= 8; k++) begin
         tick(1'b1);
         rises += int'(rise);
         if (k == 5) check("release_high_q_low_edge5", {3'b0, q}, 4'b0000);
         if (k == 6) check("release_high_rise_edge6", {2'b0, q, rise}, 4'b0011);
      end
      check("release_high_one_rise", rises[3:0], 4'b0001);

      // Chatter: toggle every clock
      q0 = q;
      rises = 0;
      falls = 0;
      for (int k = 0; k < 20; k++) begin
         tick(k[0]);
         rises += int'(rise);
         falls += int'(fall);
         check("chatter_q_const", {3'b0, q}, {3'b0, q0});
      end
      check("chatter_no_pulses", {rises[1:0], falls[1:0]}, 4'b0000);

      // Randomized runs of varying length
      for (int r = 0; r < 60; r++) begin
         dv  = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 8));
         for (int k = 0; k < len; k++) begin
            tick(dv);
            check("rise_fall_exclusive", {2'b0, rise & fall, 1'b0}, 4'b0000);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001: The block SHALL have a single parameter. DEBOUNCE_CYCLES, default 4, number of consecutive synchronized samples needed to accept a new level (legal range 2..65535).
REQ-002: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-low.
REQ-004: d  input  1  raw, possibly bouncing, asynchronous level input.
REQ-005: q  output  1  debounced, synchronized level.
REQ-006: rise  output  1  single-cycle pulse when q goes 0->1.
REQ-007: fall  output  1  single-cycle pulse when q goes 1->0.
REQ-008: busy  output  1  high while a candidate level change is being qualified.

Function
REQ-009: d SHALL pass through a two-flop synchronizer (s1, s2); only s2 feeds the control logic.
REQ-010: The FSM SHALL have four states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-011: The counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide, unsigned, and SHALL never wrap.
REQ-012: In STABLE_LO with s2=1, the FSM SHALL go to PEND_HI with cnt=1; with s2=0 it SHALL hold with cnt=0.
REQ-013: In PEND_HI with s2=0, the FSM SHALL return to STABLE_LO and set cnt=0, with no output change (glitch rejected).
REQ-014: In PEND_HI with s2=1 and cnt<DEBOUNCE_CYCLES-1, cnt SHALL increment.
REQ-015: In PEND_HI with s2=1 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL go to STABLE_HI, set q=1, set rise=1 and set cnt=0.
REQ-016: STABLE_HI and PEND_LO SHALL mirror REQ-012..015 with s2 polarity inverted, q=0 and fall=1.
REQ-017: q, rise and fall SHALL be registered outputs; rise/fall SHALL be high for exactly one cycle, the first cycle q holds its new value.
REQ-018: rise and fall SHALL never be high together.
REQ-019: busy SHALL be a decode of the state register (PEND_HI or PEND_LO), glitch-free.
REQ-020: Latency SHALL be q valid after the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples d at its new level as edge 1. This requires s2 at the new level for DEBOUNCE_CYCLES consecutive edges.
REQ-021: Any return of s2 to the current q level during PEND_* SHALL restart qualification from zero on the next departure.
REQ-022: No combinational path SHALL exist from d to any output.

Reset
REQ-023: With rst=0, s1, s2, q, rise, fall, busy and cnt SHALL be 0 and the state SHALL be STABLE_LO, immediately and without a clock edge.
REQ-024: Reset asserted mid-PEND_* SHALL abort qualification; no rise/fall pulse SHALL follow from the aborted event.
REQ-025: If d=1 at reset release, the block SHALL treat it as a normal rising event: full qualification, then q=1 with one rise pulse.

Verification
REQ-026: Bench scenarios use DEBOUNCE_CYCLES=4 and a 20-unit clock period.
REQ-027: Async reset: with d=1 and clock running, drive rst=0 between edges -> q, rise, fall and busy read 0 before the next edge.
REQ-028: Clean rise: from STABLE_LO, d 0->1 held -> busy high after edges 3..5, q=1 and rise=1 after edge 6, rise=0 after edge 7.
REQ-029: Glitch: d high for 2 cycles then low -> busy pulses, q stays 0, rise never asserts, state returns to STABLE_LO.
REQ-030: Clean fall: from STABLE_HI, d 1->0 held -> q=0 and fall=1 after edge 6, fall high exactly one cycle.
REQ-031: Reset mid-pending: rst=0 while busy=1 in PEND_HI, then release with d=0 -> q stays 0, no rise, busy=0.
REQ-032: Chatter: d toggling every clock for 20 cycles -> q constant, no rise/fall pulses.
